// File: rtl/keypad_pkg.sv
// Shared constants, event record and scan state encoding for the 5x5 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 5;
  localparam int NUM_COLS = 5;
  localparam int NUM_KEYS = 25;
  localparam int KEY_W    = 5;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic             press;
  } key_evt_t;

  typedef enum logic [1:0] {
    WAIT,
    SAMPLE,
    UPDATE
  } scan_state_t;

  // Key numbering is row-major: row*5 + col.
  function automatic logic [KEY_W-1:0] key_index(input logic [2:0] ridx, input logic [2:0] c);
    return KEY_W'(ridx) * KEY_W'(NUM_COLS) + KEY_W'(c);
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Key-event valid/ready channel between the scanner (master) and its consumer (slave).
interface keypad_scan_ctrl_if;
  import keypad_pkg::*;

  logic             evt_valid;
  logic             evt_ready;
  logic [KEY_W-1:0] evt_key;
  logic             evt_press;

  modport master (output evt_valid, output evt_key, output evt_press, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_press, output evt_ready);

endinterface

// File: rtl/keypad_evt_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO succeeds only with a same-cycle pop.
module keypad_evt_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  key_evt_t push_data,
  input  logic     pop,
  output key_evt_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  key_evt_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // The slot freed by a pop is reusable in the same cycle.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; clearing the pointers discards its contents, and
  // the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row scanner for the 5x5 keypad: samples columns once per row, debounces each key,
// and queues press/release events for a valid/ready consumer.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int CLOCKS_PER_ROW = 200000,
  parameter int SETTLE         = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] col,
  output logic [NUM_ROWS-1:0] row_en,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                scan_done,
  output logic                overflow,
  keypad_scan_ctrl_if.master  evt
);

  localparam int             CW         = $clog2(CLOCKS_PER_ROW);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(CLOCKS_PER_ROW - 1);
  localparam logic [CW-1:0]  CNT_SAMPLE = CW'(SETTLE - 1);
  localparam logic [2:0]     DB_LIMIT   = 3'(DEBOUNCE_SCANS);
  localparam logic [2:0]     ROW_LAST   = 3'(NUM_ROWS - 1);
  localparam logic [2:0]     COL_LAST   = 3'(NUM_COLS - 1);

  scan_state_t         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          ridx_q, ridx_d;
  logic [2:0]          c_q, c_d;
  logic [NUM_COLS-1:0] raw_q, raw_d;
  logic [NUM_KEYS-1:0] key_state_q, key_state_d;
  logic [2:0]          dbc_q [NUM_KEYS];
  logic [2:0]          dbc_d [NUM_KEYS];
  logic                scan_done_q, scan_done_d;
  logic                overflow_q, overflow_d;
  logic [KEY_W-1:0]    k;
  logic                push, pop, full, empty;
  key_evt_t            push_data, head;

  keypad_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign pop           = evt.evt_valid && evt.evt_ready;
  assign evt.evt_valid = !empty;
  assign evt.evt_key   = empty ? '0 : head.key;
  assign evt.evt_press = empty ? 1'b0 : head.press;
  assign row_en        = NUM_ROWS'(1) << ridx_q;
  assign key_state     = key_state_q;
  assign scan_done     = scan_done_q;
  assign overflow      = overflow_q;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    cnt_d       = cnt_q + CW'(1);
    ridx_d      = ridx_q;
    scan_done_d = 1'b0;
    state_d     = state_q;
    c_d         = c_q;
    raw_d       = raw_q;
    key_state_d = key_state_q;
    dbc_d       = dbc_q;
    push        = 1'b0;
    push_data   = '0;
    k           = key_index(ridx_q, c_q);

    if (cnt_q == CNT_LAST) begin
      cnt_d       = '0;
      ridx_d      = (ridx_q == ROW_LAST) ? 3'd0 : ridx_q + 3'd1;
      scan_done_d = (ridx_q == ROW_LAST);
    end

    case (state_q)
      // Keyed on the next count so SAMPLE coincides with cnt == SETTLE-1.
      WAIT: if (cnt_d == CNT_SAMPLE) state_d = SAMPLE;
      SAMPLE: begin
        raw_d   = ~col;
        c_d     = 3'd0;
        state_d = UPDATE;
      end
      UPDATE: begin
        if (raw_q[c_q] == key_state_q[k]) begin
          dbc_d[k] = '0;
        end else if (dbc_q[k] + 3'd1 == DB_LIMIT) begin
          key_state_d[k] = raw_q[c_q];
          dbc_d[k]       = '0;
          push           = 1'b1;
          push_data      = '{key: k, press: raw_q[c_q]};
        end else begin
          dbc_d[k] = dbc_q[k] + 3'd1;
        end
        if (c_q == COL_LAST) state_d = WAIT;
        else                 c_d     = c_q + 3'd1;
      end
      default: state_d = WAIT;
    endcase

    // A dropped event still flips key_state; only the report is lost.
    overflow_d = overflow_q | (push && full && !pop);
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT;
      cnt_q       <= '0;
      ridx_q      <= '0;
      c_q         <= '0;
      raw_q       <= '0;
      key_state_q <= '0;
      scan_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) dbc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ridx_q      <= ridx_d;
      c_q         <= c_d;
      raw_q       <= raw_d;
      key_state_q <= key_state_d;
      scan_done_q <= scan_done_d;
      overflow_q  <= overflow_d;
      dbc_q       <= dbc_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench: directed scenarios plus random key/ready traffic against a
// cycle-count based reference model of the scanner.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int CPR   = 16;
  localparam int S     = 8;
  localparam int D     = 2;
  localparam int DEPTH = 4;
  localparam int SCAN  = CPR * 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  col;
  logic [4:0]  row_en;
  logic [24:0] key_state;
  logic        scan_done;
  logic        overflow;
  logic [24:0] pressed;

  keypad_scan_ctrl_if evt_if ();

  keypad_scan_ctrl #(
    .CLOCKS_PER_ROW (CPR),
    .SETTLE         (S),
    .DEBOUNCE_SCANS (D),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row_en    (row_en),
    .key_state (key_state),
    .scan_done (scan_done),
    .overflow  (overflow),
    .evt       (evt_if.master)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col = 5'h1F;
    for (int r = 0; r < 5; r++)
      if (row_en[r]) col = ~pressed[r*5 +: 5];
  end

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: time since reset decides where the scan is.
  int          t;
  logic [24:0] m_ks;
  int          m_dbc [25];
  logic [4:0]  m_raw;
  key_evt_t    m_q [$];
  logic        m_ovf;
  logic [24:0] p_pressed;
  logic        p_ready, p_rst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_edge();
    int cnt, r, c, k;
    if (p_rst) begin
      t = 0; m_ks = '0; m_raw = '0; m_ovf = 1'b0; m_q.delete();
      foreach (m_dbc[i]) m_dbc[i] = 0;
      return;
    end
    cnt = t % CPR;
    r   = (t / CPR) % 5;
    if (p_ready && m_q.size() > 0) void'(m_q.pop_front());
    if (cnt == S - 1)
      for (int i = 0; i < 5; i++) m_raw[i] = p_pressed[r*5 + i];
    if (cnt >= S && cnt < S + 5) begin
      c = cnt - S;
      k = r * 5 + c;
      if (m_raw[c] == m_ks[k]) m_dbc[k] = 0;
      else if (m_dbc[k] + 1 == D) begin
        m_ks[k]  = m_raw[c];
        m_dbc[k] = 0;
        if (m_q.size() < DEPTH) m_q.push_back('{key: 5'(k), press: m_raw[c]});
        else                    m_ovf = 1'b1;
      end else m_dbc[k]++;
    end
    t++;
  endtask

  task automatic check_all();
    check("row_en",    32'(row_en),    32'(1) << ((t / CPR) % 5));
    check("scan_done", 32'(scan_done), 32'((t % SCAN == 0) && (t > 0)));
    check("key_state", 32'(key_state), 32'(m_ks));
    check("evt_valid", 32'(evt_if.evt_valid), 32'(m_q.size() != 0));
    check("evt_key",   32'(evt_if.evt_key),   (m_q.size() != 0) ? 32'(m_q[0].key)   : 32'd0);
    check("evt_press", 32'(evt_if.evt_press), (m_q.size() != 0) ? 32'(m_q[0].press) : 32'd0);
    check("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  task automatic tick();
    p_pressed = pressed;
    p_ready   = evt_if.evt_ready;
    p_rst     = rst;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_row_en"},    32'(row_en),           32'h1);
    check({tag, "_key_state"}, 32'(key_state),        32'h0);
    check({tag, "_scan_done"}, 32'(scan_done),        32'h0);
    check({tag, "_evt_valid"}, 32'(evt_if.evt_valid), 32'h0);
    check({tag, "_evt_key"},   32'(evt_if.evt_key),   32'h0);
    check({tag, "_overflow"},  32'(overflow),         32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    key_evt_t got [$];
    t = 0;
    rst = 1'b1;
    pressed = '0;
    evt_if.evt_ready = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;

    // Idle: three scans with no keys.
    repeat (3 * SCAN) tick();
    check("idle_key_state", 32'(key_state), 32'h0);

    // Single press of key 7 for two scans, then consume the event.
    pressed = 25'(1) << 7;
    repeat (2 * SCAN) tick();
    check("press_ks7",  32'(key_state[7]),     32'd1);
    check("press_key",  32'(evt_if.evt_key),   32'd7);
    check("press_dir",  32'(evt_if.evt_press), 32'd1);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    check("press_popped", 32'(evt_if.evt_valid), 32'd0);

    // Release for two scans.
    pressed = '0;
    repeat (2 * SCAN) tick();
    check("release_ks7", 32'(key_state[7]),     32'd0);
    check("release_key", 32'(evt_if.evt_key),   32'd7);
    check("release_dir", 32'(evt_if.evt_press), 32'd0);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;

    // Glitch: one scan pressed is shorter than the debounce window.
    pressed = 25'(1) << 7;
    repeat (SCAN) tick();
    pressed = '0;
    repeat (2 * SCAN) tick();
    check("glitch_ks7",   32'(key_state[7]),     32'd0);
    check("glitch_valid", 32'(evt_if.evt_valid), 32'd0);

    // Whole row 3 pressed with no consumer: four queued, key 19 dropped.
    pressed = 25'h1F << 15;
    repeat (2 * SCAN) tick();
    check("ovf_flag",  32'(overflow),        32'd1);
    check("ovf_keys",  32'(key_state),       32'h000F8000);
    check("ovf_head",  32'(evt_if.evt_key),  32'd15);

    // Random-ready drain; events must leave in order 15..18.
    for (int i = 0; i < 200 && got.size() < 4; i++) begin
      evt_if.evt_ready = 1'($urandom_range(0, 1));
      if (evt_if.evt_valid && evt_if.evt_ready)
        got.push_back('{key: evt_if.evt_key, press: evt_if.evt_press});
      tick();
    end
    evt_if.evt_ready = 1'b0;
    check("drain_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++) begin
      check("drain_key",   32'(got[i].key),   32'(15 + i));
      check("drain_press", 32'(got[i].press), 32'd1);
    end

    // Reset in the middle of a row update.
    for (int i = 0; i < CPR && (t % CPR) != S + 2; i++) tick();
    rst = 1'b1;
    tick();
    check_reset_values("midrst");
    rst = 1'b0;

    // Row 3 still held: FIFO fills, and the fifth push meets a pop.
    for (int i = 0; i < 2 * SCAN; i++) begin
      evt_if.evt_ready = ((t % SCAN) == 3 * CPR + S + 4);
      tick();
    end
    evt_if.evt_ready = 1'b0;
    check("fullpop_ovf",  32'(overflow),       32'd0);
    check("fullpop_head", 32'(evt_if.evt_key), 32'd16);
    check("fullpop_keys", 32'(key_state),      32'h000F8000);

    // Random key patterns and random consumer.
    for (int s = 0; s < 6; s++) begin
      pressed = 25'($urandom);
      for (int i = 0; i < SCAN; i++) begin
        evt_if.evt_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end

    // Release everything and drain.
    pressed = '0;
    evt_if.evt_ready = 1'b1;
    repeat (3 * SCAN) tick();
    check("final_keys",  32'(key_state),        32'h0);
    check("final_valid", 32'(evt_if.evt_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 5x5 Sword keypad. It sequences the row drive and samples the columns at a fixed cadence. It debounces all 25 keys and keeps a debounced key-state vector. Every debounced press or release becomes an event in a small FIFO, which downstream logic drains through a valid/ready handshake. The block sits between the keypad pins (via top-level tristate buffers) and any consumer such as the LED display or a UART reporter.

## Interface

Parameters:
- CLOCKS_PER_ROW, 200000: clocks spent on each row (1 ms at 200 MHz).
- SETTLE, 100000: clock count within a row at which the columns are sampled. Must satisfy SETTLE+6 <= CLOCKS_PER_ROW.
- DEBOUNCE_SCANS, 4: number of consecutive differing samples that flip a key's stable state. Range 1..7.
- FIFO_DEPTH, 8: event FIFO depth. Must be a power of two.

Ports:
- clk, in, 1: single system clock.
- rst, in, 1: synchronous, active-high reset.
- col, in, 5: keypad column inputs. A bit reads 0 when the key in the driven row is pressed.
- row_en, out, 5: one-hot drive for the active row. The top level drives that pin 0 and holds all other row pins at Z.
- key_state, out, 25: debounced state, bit index row*5+col. 1 means pressed.
- scan_done, out, 1: one-cycle pulse when row 4 finishes.
- evt_valid, out, 1: the FIFO holds an event.
- evt_ready, in, 1: the consumer accepts the head event.
- evt_key, out, 5: key index of the head event, 0..24.
- evt_press, out, 1: 1 for a press event, 0 for a release event.
- overflow, out, 1: sticky flag; set when an event was dropped; cleared only by rst.

## Operation

- Counter `cnt` counts 0..CLOCKS_PER_ROW-1 and row index `ridx` counts 0..4.
  - `row_en` = 1 << ridx.
  - When cnt == CLOCKS_PER_ROW-1: cnt goes to 0 and ridx advances, wrapping 4 -> 0.
  - scan_done pulses in the cycle after ridx wraps from 4.
- State machine states: WAIT, SAMPLE, UPDATE.
  - WAIT -> SAMPLE when cnt == SETTLE-1.
  - SAMPLE (1 cycle): register `raw = ~col`, then go to UPDATE with column index c = 0.
  - UPDATE (5 cycles, c = 0..4): process key k = ridx*5+c, then c+1. After c = 4, return to WAIT.
- Debounce, one 3-bit counter per key, applied during UPDATE:
  - If raw[c] == key_state[k]: counter <= 0.
  - Else, if counter+1 == DEBOUNCE_SCANS: flip key_state[k], counter <= 0, and push event {k, new state}.
  - Else: counter <= counter+1.
- Event FIFO, first-word-fall-through:
  - evt_valid = not empty; evt_key and evt_press show the head entry.
  - Pop happens when evt_valid && evt_ready.
  - evt_ready while empty is ignored.
- Boundary conditions:
  - Push while full with no pop: the event is dropped and overflow <= 1. key_state still flips.
  - Push while full with a simultaneous pop: both happen, no overflow.
  - Push while empty: evt_valid rises the next cycle.
  - At most 5 events per row sample and 1 per cycle, so no internal backpressure is needed.
- Reset takes effect at any point, including mid-UPDATE or mid-handshake. The next clock returns every register to its reset value, and the FIFO contents are discarded.

## Timing

- Reset values: cnt = 0, ridx = 0, row_en = 5'b00001, state = WAIT, key_state = 0, all debounce counters = 0, scan_done = 0, evt_valid = 0, evt_key = 0, evt_press = 0, overflow = 0.
- Column sample: col is captured on the clock edge ending the cycle where cnt == SETTLE-1.
- Key processing: key ridx*5+c updates key_state in the cycle ending at cnt == SETTLE+c.
- Event latency: evt_valid is visible 1 cycle after the UPDATE cycle that pushes the event, when the FIFO was empty.
- Row switch: row_en changes in the cycle after cnt == CLOCKS_PER_ROW-1. This gives a full SETTLE interval before the next sample.
- Debounce time: a change held for D full scans is reported in scan D. Worst-case delay is D*5*CLOCKS_PER_ROW clocks.

## Structure

- Package keypad_pkg holds:
  - constants NUM_ROWS = 5, NUM_COLS = 5, NUM_KEYS = 25, KEY_W = 5;
  - typedef key_evt_t {logic [4:0] key; logic press;};
  - the state enum {WAIT, SAMPLE, UPDATE}.
- Sub-module keypad_evt_fifo: parameterised FWFT FIFO of key_evt_t with push, pop, full and empty. The simultaneous push/pop-when-full rule lives inside it.
- The scan/debounce FSM lives in keypad_scan_ctrl.

## Test plan

All scenarios use CLOCKS_PER_ROW = 16, SETTLE = 8, DEBOUNCE_SCANS = 2, FIFO_DEPTH = 4.

- Reset and idle: hold col = 5'h1F for 3 scans. Expect row_en cycling 1, 2, 4, 8, 16 every 16 clocks, scan_done every 80 clocks, key_state = 0 and evt_valid = 0.
- Single press: drive col[2] = 0 whenever row_en = 5'b00010 (key 7) for 2 scans. Expect key_state[7] = 1 at cnt = 10 of the second row-1 visit, then an event {7, 1}. After release for 2 scans, expect event {7, 0}.
- Glitch rejection: key 7 pressed for 1 scan only. Expect no event and key_state[7] = 0.
- Multi-key and overflow: all 5 keys of row 3 pressed with evt_ready = 0. Expect events for keys 15..18 queued and key 19 dropped, overflow = 1, key_state[19:15] = 5'h1F.
- Full with simultaneous pop: hold evt_ready = 1 during the UPDATE cycles while the FIFO is full. Expect no overflow.
- Handshake and reset: toggle evt_ready randomly and check the events drain in order {15, 1} .. {18, 1}. Then assert rst mid-UPDATE; expect all outputs back to their reset values on the next clock.
